// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle MULT/DIV engine: FSM state encoding,
// operation select values and default operand/counter sizes.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits. Purely combinational.
module div_restore_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] trial;

  // rem_i < dvsr_i always holds, so a successful subtraction fits in WIDTH bits.
  always_comb begin
    trial     = {rem_i, dvd_bit_i};
    quo_bit_o = (trial >= {1'b0, dvsr_i});
    rem_o     = quo_bit_o ? (trial[WIDTH-1:0] - dvsr_i) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Signed MULT (radix-2 Booth, Done WIDTH+1 cycles after Start) and DIV (restoring, Done
// WIDTH+2 cycles after Start) engine; Start is ignored while Busy. Optional MULTDIV_ABORT_EN adds Abort.
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             Reset_In,
  input  logic             Start,
  input  logic             Op,
`ifdef MULTDIV_ABORT_EN
  input  logic             Abort,
`endif
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Zero_Div
);

  state_t state_q, state_d;

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             abort_w;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   opnd_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_mq;
  logic [WIDTH-1:0] div_rem;
  logic             div_quo_bit;

`ifdef MULTDIV_ABORT_EN
  assign abort_w = Abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && Start && !abort_w;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign a_mag     = A_In[WIDTH-1] ? -A_In : A_In;
  assign b_mag     = B_In[WIDTH-1] ? -B_In : B_In;

  // The accumulator carries one guard bit so that subtracting a most-negative
  // multiplicand does not wrap before the arithmetic shift.
  always_comb begin
    opnd_ext  = {opnd_q[WIDTH-1], opnd_q};
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + opnd_ext;
      2'b10:   booth_sum = acc_q - opnd_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_mq  = {booth_sum[0], mq_q[WIDTH-1:1]};
  end

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .dvd_bit_i (mq_q[WIDTH-1]),
    .dvsr_i    (opnd_q),
    .rem_o     (div_rem),
    .quo_bit_o (div_quo_bit)
  );

  always_ff @(posedge clk or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (Op == OP_MULT)      state_d = ST_MULT;
          else if (B_In == '0)    state_d = ST_DONE;
          else                    state_d = ST_DIV;
        end
      end
      ST_MULT: begin
        if (abort_w)              state_d = ST_IDLE;
        else if (last_step)       state_d = ST_DONE;
      end
      ST_DIV: begin
        if (abort_w)              state_d = ST_IDLE;
        else if (last_step)       state_d = ST_FIX;
      end
      ST_FIX:                     state_d = abort_w ? ST_IDLE : ST_DONE;
      ST_DONE:                    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state_q != ST_IDLE);
    Done     = (state_q == ST_DONE);
    Zero_Div = (state_q == ST_DONE) && zdiv_q;
    Hi       = hi_q;
    Lo       = lo_q;
  end

  // mq holds the multiplier during MULT and the dividend shifting into the quotient during DIV.
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    qm1_d     = qm1_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zdiv_d    = zdiv_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d     = '0;
          qm1_d     = 1'b0;
          cnt_d     = '0;
          zdiv_d    = (Op == OP_DIV) && (B_In == '0);
          neg_quo_d = A_In[WIDTH-1] ^ B_In[WIDTH-1];
          neg_rem_d = A_In[WIDTH-1];
          if (Op == OP_MULT) begin
            mq_d   = B_In;
            opnd_d = A_In;
          end else begin
            mq_d   = a_mag;
            opnd_d = b_mag;
          end
        end
      end
      ST_MULT: begin
        if (!abort_w) begin
          acc_d = booth_acc;
          mq_d  = booth_mq;
          qm1_d = mq_q[0];
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            hi_d = booth_acc[WIDTH-1:0];
            lo_d = booth_mq;
          end
        end
      end
      ST_DIV: begin
        if (!abort_w) begin
          acc_d = {1'b0, div_rem};
          mq_d  = {mq_q[WIDTH-2:0], div_quo_bit};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX: begin
        if (!abort_w) begin
          hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          lo_d = neg_quo_q ? -mq_q : mq_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_In) begin
    if (!Reset_In) begin
      acc_q     <= '0;
      mq_q      <= '0;
      qm1_q     <= 1'b0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zdiv_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      qm1_q     <= qm1_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zdiv_q    <= zdiv_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed + random bench for mult_div_sequencer; expected results come from a
// native signed-arithmetic model pushed to a scoreboard when each Start is driven.
module tb_mult_div_sequencer;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         Reset_In;
  logic         Start;
  logic         Op;
  logic [W-1:0] A_In;
  logic [W-1:0] B_In;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;
  logic         Zero_Div;
`ifdef MULTDIV_ABORT_EN
  logic         Abort;
`endif

  always #5 clk = ~clk;

  mult_div_sequencer #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .Reset_In (Reset_In),
    .Start    (Start),
    .Op       (Op),
`ifdef MULTDIV_ABORT_EN
    .Abort    (Abort),
`endif
    .A_In     (A_In),
    .B_In     (B_In),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .Zero_Div (Zero_Div)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zd;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sbv, p, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == OP_MULT) begin
      p     = sa * sbv;
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.zd  = 1'b0;
      e.lat = W + 1;
    end else if (b == '0) begin
      e.hi  = last_hi;
      e.lo  = last_lo;
      e.zd  = 1'b1;
      e.lat = 1;
    end else begin
      p     = sa / sbv;
      r     = sa % sbv;
      e.lo  = p[31:0];
      e.hi  = r[31:0];
      e.zd  = 1'b0;
      e.lat = W + 2;
    end
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns one edge later (cycle 1).
  task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    push_exp(op, a, b);
    Start = 1'b1;
    Op    = op;
    A_In  = a;
    B_In  = b;
    @(posedge clk); #1;
    Start = 1'b0;
    Op    = ~op;
    A_In  = $urandom;
    B_In  = $urandom;
  endtask

  task automatic wait_done(input string tag, input int inject_cyc);
    exp_t e;
    int   cyc;
    logic busy_ok;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!Done && cyc < 200) begin
      busy_ok &= Busy;
      if (cyc == inject_cyc) begin
        Start = 1'b1;
        Op    = OP_DIV;
        A_In  = 32'd100;
        B_In  = 32'd7;
      end
      @(posedge clk); #1;
      Start = 1'b0;
      cyc++;
    end
    check_bit({tag, " done_seen"}, Done, 1'b1);
    if (Done) begin
      check_bit({tag, " busy_whole_op"}, busy_ok & Busy, 1'b1);
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL %s scoreboard: observed Done with 0 entries expected 1 entry", tag);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, " latency"}, W'(cyc), W'(e.lat));
        check({tag, " hi"}, Hi, e.hi);
        check({tag, " lo"}, Lo, e.lo);
        check_bit({tag, " zero_div"}, Zero_Div, e.zd);
        if (!e.zd) begin
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end
      @(posedge clk); #1;
      check_bit({tag, " done_fall"}, Done, 1'b0);
      check_bit({tag, " busy_fall"}, Busy, 1'b0);
      check_bit({tag, " zdiv_fall"}, Zero_Div, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         idle_busy;
    logic         seen_done;
    logic [W-1:0] ra, rb;
    logic         rop;

    Reset_In = 1'b0;
    Start    = 1'b0;
    Op       = 1'b0;
    A_In     = '0;
    B_In     = '0;
`ifdef MULTDIV_ABORT_EN
    Abort    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", Hi, '0);
    check("reset lo", Lo, '0);
    check_bit("reset busy", Busy, 1'b0);
    check_bit("reset done", Done, 1'b0);
    check_bit("reset zdiv", Zero_Div, 1'b0);
    Reset_In = 1'b1;
    @(posedge clk); #1;

    start_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul_7_x_m3", 0);
    check("mul_7_x_m3 hi const", Hi, 32'hFFFF_FFFF);
    check("mul_7_x_m3 lo const", Lo, 32'hFFFF_FFEB);

    start_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul_min_x_min", 0);
    check("mul_min_x_min hi const", Hi, 32'h4000_0000);
    check("mul_min_x_min lo const", Lo, 32'h0000_0000);

    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_by_2", 0);
    check("div_m7_by_2 lo const", Lo, 32'hFFFF_FFFD);
    check("div_m7_by_2 hi const", Hi, 32'hFFFF_FFFF);

    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_overflow", 0);
    check("div_overflow lo const", Lo, 32'h8000_0000);
    check("div_overflow hi const", Hi, 32'h0000_0000);

    start_op(OP_DIV, 32'h451, 32'h20);
    wait_done("div_setup_11_22", 0);

    start_op(OP_DIV, 32'd5, 32'd0);
    wait_done("div_by_zero", 0);
    check("div_by_zero hi held", Hi, 32'h11);
    check("div_by_zero lo held", Lo, 32'h22);

    start_op(OP_MULT, 32'd3, 32'd4);
    wait_done("mul_3x4_busy_start", 10);
    check("mul_3x4 hi const", Hi, 32'd0);
    check("mul_3x4 lo const", Lo, 32'd12);
    idle_busy = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      idle_busy |= Busy;
    end
    check_bit("start_while_busy not queued", idle_busy, 1'b0);

    start_op(OP_MULT, 32'd3, 32'd4);
    repeat (19) begin
      @(posedge clk); #1;
    end
    Reset_In = 1'b0;
    #1;
    check("midop_reset hi", Hi, '0);
    check("midop_reset lo", Lo, '0);
    check_bit("midop_reset busy", Busy, 1'b0);
    check_bit("midop_reset done", Done, 1'b0);
    check_bit("midop_reset zdiv", Zero_Div, 1'b0);
    exp_q.delete();
    last_hi = '0;
    last_lo = '0;
    Reset_In = 1'b1;
    @(posedge clk); #1;
    start_op(OP_MULT, 32'd5, 32'hFFFF_FFFA);
    wait_done("after_reset_mul", 0);

    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = (i % 2 == 1);
      if (i == 6) rb = 32'hFFFF_FFFF;
      if (rop && rb == '0) rb = 32'd1;
      start_op(rop, ra, rb);
      wait_done($sformatf("rand_%0d", i), 0);
    end

`ifdef MULTDIV_ABORT_EN
    start_op(OP_DIV, 32'd1000, 32'd7);
    repeat (14) begin
      @(posedge clk); #1;
    end
    Abort = 1'b1;
    @(posedge clk); #1;
    Abort = 1'b0;
    check_bit("abort busy", Busy, 1'b0);
    check_bit("abort done", Done, 1'b0);
    check("abort hi held", Hi, last_hi);
    check("abort lo held", Lo, last_lo);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= Done | Zero_Div;
    end
    check_bit("abort no done pulse", seen_done, 1'b0);
    exp_q.delete();
    Abort = 1'b1;
    Start = 1'b1;
    Op    = OP_MULT;
    A_In  = 32'd3;
    B_In  = 32'd4;
    @(posedge clk); #1;
    Abort = 1'b0;
    Start = 1'b0;
    check_bit("abort beats start", Busy, 1'b0);
`else
    seen_done = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
Multicycle signed MULT/DIV engine for the MIPS-subset datapath, with its sequencing FSM. The main control unit pulses Start with an operation select and stalls until Done. It then loads Hi/Lo into the HIGH/LOW registers through High_Load/Low_Load. Zero_Div is reported to the control unit, which raises the exception.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- Reset_In  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Op  in  1  0 = MULT, 1 = DIV.
- A_In  in  WIDTH  rs value (multiplicand / dividend).
- B_In  in  WIDTH  rt value (multiplier / divisor).
- Hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
- Lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse; Hi/Lo are valid in that cycle.
- Zero_Div  out  1  one-cycle pulse, coincident with Done, when the divisor is 0.

Behaviour:
- Reset (Reset_In = 0, asynchronous):
  - state = IDLE.
  - Hi, Lo, Busy, Done, Zero_Div, counter and internal registers all 0.
- States: IDLE, MULT, DIV, FIX, DONE. Encoding comes from the shared package.
- IDLE:
  - Start = 1 latches A_In, B_In and Op, and clears the counter.
  - Op = 0 goes to MULT.
  - Op = 1 with B_In != 0 goes to DIV.
  - Op = 1 with B_In = 0 goes to DONE with the zero-divide flag set.
- Cycle numbering: cycle 0 is the edge that accepts Start.
- MULT:
  - Radix-2 Booth on a {acc[W], mplier[W], q-1} register; one step per cycle.
  - Exactly WIDTH steps (cycles 1..WIDTH), then DONE.
  - Done is high in cycle WIDTH+1, with Hi:Lo = signed 2W-bit product.
- DIV:
  - At latch, operands are converted to unsigned magnitudes (WIDTH bits, so |0x80000000| = 2^31) and the two signs are recorded.
  - Restoring division: one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (one cycle):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Then goes to DONE. Done is high in cycle WIDTH+2.
- DONE:
  - Done = 1 for one cycle.
  - Hi/Lo are updated on entry to DONE, except on a zero divide.
  - Returns to IDLE next cycle. Done falls and Busy falls.
- Zero divide:
  - Done and Zero_Div are both high in cycle 1.
  - Hi/Lo keep their previous values.
- Overflow case 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0, with no exception.
- Start while Busy is ignored. No queuing; A_In and B_In changes mid-operation have no effect.
- Hi/Lo hold their value between operations. They change only on entry to DONE.
- All arithmetic is modulo 2^WIDTH per half. The counter compares against WIDTH-1.

Optional Feature:
- Macro MULTDIV_ABORT_EN.
- When defined:
  - Adds input port Abort (1 bit).
  - Abort = 1 in MULT, DIV or FIX returns to IDLE on the next edge.
  - Busy drops in that same cycle, Hi/Lo are unchanged, and no Done or Zero_Div pulse is produced.
  - Abort has priority over Start in IDLE, so the request is dropped.
- When undefined: no Abort port, and an operation always runs to completion.

Decomposition:
- Shared package mult_div_pkg:
  - state encoding constants (IDLE, MULT, DIV, FIX, DONE);
  - OP_MULT = 0, OP_DIV = 1;
  - default WIDTH.
- One combinational sub-module, div_restore_step:
  - inputs: partial remainder, dividend bit, divisor magnitude;
  - outputs: next remainder and quotient bit.
- Booth step and FSM stay inline.

Test Plan:
- MULT 7 × 0xFFFFFFFD (−3): Start at cycle 0, Done at cycle 33, Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB, Busy high in cycles 1..33.
- MULT 0x80000000 × 0x80000000: Hi = 0x40000000, Lo = 0x00000000.
- DIV 0xFFFFFFF9 (−7) / 2: Done at cycle 34, Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0.
- DIV 5 / 0 with previous Hi = 0x11, Lo = 0x22: Done and Zero_Div both high in cycle 1, Hi = 0x11, Lo = 0x22 unchanged, Busy low by cycle 2.
- Start MULT 3 × 4; pulse Start DIV at cycle 10; drive Reset_In low at cycle 20 in a second run:
  - first run: the cycle-10 Start is ignored, result is Hi = 0, Lo = 12;
  - second run: all outputs go to 0 immediately, a new Start after release works normally.
- MULTDIV_ABORT_EN: Abort at cycle 15 of a DIV returns to IDLE at cycle 16, with no Done and Hi/Lo unchanged.
